// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared project defaults for the button conditioner
package button_conditioner_pkg;
  localparam int CLK_HZ = 12_000_000;
  localparam int N_BTN_DEFAULT = 4;
  localparam int SW_W_DEFAULT = 8;
  localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;
  function automatic int cnt_width(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: sync, polarity fix, stable-count debounce and edge pulses for one button
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  logic hit;
  assign s = sync[1] ^ ACTIVE_LOW;
  assign hit = (s != level) && (cnt == TERM);
  // any disagreement that survives TERM+1 edges flips the level; agreement restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      cnt   <= (s == level || hit) ? '0 : cnt + 1'b1;
      level <= hit ? s : level;
      rise  <= hit && s;
      fall  <= hit && !s;
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced buttons with press/release pulses and a switch snapshot
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int               N_BTN           = N_BTN_DEFAULT,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = 4'b1000,
  parameter int               SW_W            = SW_W_DEFAULT,
  parameter int               CAPTURE_IDX     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [SW_W-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [SW_W-1:0]  sw_sync,
  output logic [SW_W-1:0]  stored_value,
  output logic             stored_valid
);
  logic [SW_W-1:0] sw_meta;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .rise (btn_press[i]),
      .fall (btn_release[i])
    );
  end
  // two-flop switch sync and snapshot on the capture button's press pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta      <= '0;
      sw_sync      <= '0;
      stored_value <= '0;
      stored_valid <= 1'b0;
    end else begin
      sw_meta      <= sw_raw;
      sw_sync      <= sw_meta;
      stored_value <= btn_press[CAPTURE_IDX] ? sw_sync : stored_value;
      stored_valid <= stored_valid | btn_press[CAPTURE_IDX];
    end
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 4, number of button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 120000 (10 ms at 12 MHz), consecutive stable cycles required to accept a level change; legal range 2..2^20.
REQ-003 Parameter ACTIVE_LOW_MASK, N_BTN bits, default 4'b1000, bit i set means raw channel i is pressed when low (BTN_N style).
REQ-004 Parameter SW_W, default 8, switch bus width.
REQ-005 Parameter CAPTURE_IDX, default 3, channel whose press event captures the switch bus.
REQ-006 CLK  in  1  single system clock; all state changes on its rising edge.
REQ-007 RST  in  1  reset, synchronous and active-high.
REQ-008 btn_raw  in  N_BTN  asynchronous raw button pins.
REQ-009 sw_raw  in  SW_W  asynchronous raw switch pins.
REQ-010 btn_level  out  N_BTN  debounced, polarity-corrected state, 1 = pressed.
REQ-011 btn_press  out  N_BTN  one-cycle pulse on accepted press.
REQ-012 btn_release  out  N_BTN  one-cycle pulse on accepted release.
REQ-013 sw_sync  out  SW_W  two-flop-synchronized switch value, no debounce.
REQ-014 stored_value  out  SW_W  switch snapshot taken on capture press.
REQ-015 stored_valid  out  1  high once at least one capture has occurred since reset.

Function
REQ-016 Each btn_raw bit SHALL pass through a two-flop synchronizer, then an XOR with its ACTIVE_LOW_MASK bit, giving sample s[i].
REQ-017 Each channel SHALL hold level L[i] and a counter C[i] of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-018 When s[i] == L[i], C[i] SHALL clear to 0 on the next edge (any bounce restarts the count).
REQ-019 When s[i] != L[i] and C[i] < DEBOUNCE_CYCLES-1, C[i] SHALL increment.
REQ-020 When s[i] != L[i] and C[i] == DEBOUNCE_CYCLES-1, L[i] SHALL take s[i] and C[i] SHALL clear, on the same edge.
REQ-021 Latency: a clean raw change SHALL appear on btn_level exactly DEBOUNCE_CYCLES+2 rising edges after it, counting the first edge that samples it.
REQ-022 btn_press[i] SHALL be high for exactly the one cycle following the edge where L[i] goes 0->1; btn_release[i] likewise for 1->0; never both in one cycle.
REQ-023 A pulse shorter than DEBOUNCE_CYCLES cycles (after sync) SHALL produce no level change and no pulse.
REQ-024 Channels SHALL be independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-025 sw_sync SHALL be sw_raw delayed through two flops.
REQ-026 On the edge where btn_press[CAPTURE_IDX] is high, stored_value SHALL load sw_sync and stored_valid SHALL set; otherwise stored_value holds.
REQ-027 Counter SHALL never wrap; saturation is impossible because REQ-020 clears it at terminal count.

Reset
REQ-028 While RST is high at an edge: synchronizer flops, L, C, btn_press, btn_release, sw_sync, stored_value and stored_valid SHALL all become 0.
REQ-029 A button held pressed through reset release SHALL be reported as a normal press DEBOUNCE_CYCLES+2 edges after RST deasserts.
REQ-030 RST asserted mid-count SHALL abandon the count with no pulse emitted.

Structure
REQ-031 Default DEBOUNCE_CYCLES, N_BTN, SW_W and the clock-frequency constant SHALL live in the shared project package/include, not in this module.
REQ-032 One sub-module, debounce_channel (sync, polarity, counter, level, edge pulses for one bit), SHALL be instantiated N_BTN times.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-033 Clean press on btn_raw[0] held 20 cycles -> btn_level[0] high after edge 6, btn_press[0] high one cycle, no release pulse.
REQ-034 Bounce 1,0,1,0 at 2-cycle spacing, then stable high -> exactly one btn_press, 6 edges after the final rising transition.
REQ-035 btn_raw[3] (active-low) held low with sw_raw=8'hA5, then sw_raw=8'h3C -> stored_value=8'hA5 one edge after btn_press[3], stored_valid=1, stays 8'hA5.
REQ-036 Buttons 0 and 1 pressed same cycle -> btn_press=4'b0011 in a single cycle.
REQ-037 RST pulsed 2 cycles into a press count -> no pulse during reset; press reported 6 edges after RST deasserts with the button still held.
REQ-038 3-cycle glitch with DEBOUNCE_CYCLES=4 -> btn_level, btn_press, btn_release all stay 0.
